// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Program store plus PC that issues each instruction word to the
//               control unit for exactly as many cycles as it takes to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int DWELL_STD   = 3,
  parameter int DWELL_LDR   = 4,
  parameter int DWELL_STR   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted
);

  localparam int c_DEPTH = 1 << PC_BITS;
  localparam int c_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [INSTR_WIDTH-1:0] r_mem [c_DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic [PC_BITS-1:0]     r_pc, w_pc_nxt;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_halted, w_halted_nxt;

  logic [PC_BITS-1:0]     w_pc_inc;
  logic [INSTR_WIDTH-1:0] w_first_word;
  logic [INSTR_WIDTH-1:0] w_next_word;
  logic [1:0]             w_first_type;
  logic [1:0]             w_next_type;
  logic                   w_load_ok;

  function automatic logic [c_CNT_W-1:0] dwell(input logic [1:0] t);
    case (t)
      2'b01:   dwell = c_CNT_W'(DWELL_STD);
      2'b10:   dwell = c_CNT_W'(DWELL_LDR);
      2'b11:   dwell = c_CNT_W'(DWELL_STR);
      default: dwell = '0;
    endcase
  endfunction

  assign w_pc_inc     = r_pc + PC_BITS'(1);
  assign w_first_word = r_mem[0];
  assign w_next_word  = r_mem[w_pc_inc];
  assign w_first_type = w_first_word[INSTR_WIDTH-1 -: 2];
  assign w_next_type  = w_next_word[INSTR_WIDTH-1 -: 2];
  assign w_load_ok    = load_en && (r_state == S_IDLE || r_state == S_HALT);

  // A write in the start cycle lands before LEAD reads word 0 (write-first).
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_instr  <= w_instr_nxt;
      r_pc     <= w_pc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = r_instr;
    w_pc_nxt     = r_pc;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_halted_nxt = r_halted;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LEAD;
        end
      end
      S_HALT: begin
        if (start) begin
          w_state_nxt  = S_LEAD;
          w_halted_nxt = 1'b0;
        end
      end
      S_LEAD: begin
        w_instr_nxt = w_first_word;
        w_pc_nxt    = '0;
        if (w_first_type == 2'b00) begin
          w_state_nxt  = S_HALT;
          w_busy_nxt   = 1'b0;
          w_halted_nxt = 1'b1;
        end else begin
          // Extra cycle covers the control unit's reset-state sample.
          w_state_nxt = S_ISSUE;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = dwell(w_first_type) + c_CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (r_cnt > c_CNT_W'(1)) begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end else if (r_pc == {PC_BITS{1'b1}}) begin
          w_state_nxt  = S_HALT;
          w_instr_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_halted_nxt = 1'b1;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_instr_nxt = w_next_word;
          w_cnt_nxt   = dwell(w_next_type);
          if (w_next_type == 2'b00) begin
            w_state_nxt  = S_HALT;
            w_busy_nxt   = 1'b0;
            w_halted_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign instr  = r_instr;
  assign pc     = r_pc;
  assign busy   = r_busy;
  assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed bench for instr_fetch; a schedule model predicts every
//               cycle's outputs, literal checks pin hold lengths and end states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int W  = 20;
  localparam int PB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [PB-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [W-1:0]  instr;
  logic [PB-1:0] pc;
  logic          busy;
  logic          halted;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .instr     (instr),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // ---------------- model: per-cycle schedule expanded at start ----------------
  typedef struct packed {
    logic [W-1:0]  instr;
    logic [PB-1:0] pc;
    logic          busy;
    logic          halted;
  } exp_t;

  exp_t         q[$];
  exp_t         e = '0;
  logic [W-1:0] shadow [32];

  function automatic int hold_of(input logic [1:0] t);
    return (t == 2'b10) ? 4 : 3;
  endfunction

  task automatic build_schedule();
    logic [W-1:0] w;
    q.delete();
    q.push_back('{e.instr, e.pc, 1'b0, 1'b0});
    for (int i = 0; i < 32; i++) begin
      w = shadow[i];
      if (w[19:18] == 2'b00) begin
        q.push_back('{w, PB'(i), 1'b0, 1'b1});
        break;
      end
      for (int k = 0; k < hold_of(w[19:18]) + ((i == 0) ? 1 : 0); k++)
        q.push_back('{w, PB'(i), 1'b1, 1'b0});
      if (i == 31) q.push_back('{20'h0, 5'd31, 1'b0, 1'b1});
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e = '0;
    end else if (q.size() == 0) begin
      if (load_en) shadow[load_addr] = load_data;
      if (start) begin
        build_schedule();
        e = q.pop_front();
      end
    end else begin
      e = q.pop_front();
    end
    #1;
    cyc++;
    chk("instr",  32'(instr),  32'(e.instr));
    chk("pc",     32'(pc),     32'(e.pc));
    chk("busy",   32'(busy),   32'(e.busy));
    chk("halted", 32'(halted), 32'(e.halted));
  end

  // ---------------- stimulus helpers ----------------
  int           seg_len[$];
  logic [PB-1:0] seg_pc[$];
  logic [W-1:0] seg_word[$];

  task automatic load_word(input logic [PB-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Pulses start and records each busy hold as (pc, word, length) until halted.
  task automatic run_prog();
    bit done = 0;
    seg_len.delete(); seg_pc.delete(); seg_word.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #2;
      if (busy) begin
        if (seg_pc.size() == 0 || seg_pc[$] != pc) begin
          seg_pc.push_back(pc); seg_word.push_back(instr); seg_len.push_back(1);
        end else begin
          seg_len[$] = seg_len[$] + 1;
        end
      end
      if (halted) done = 1;
    end
    chk("run_reaches_halt", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset then idle
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_instr", 32'(instr), 32'h0);
    chk("idle_pc", 32'(pc), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_halted", 32'(halted), 32'h0);

    // Single std_op
    load_word(5'd0, 20'h41102);
    load_word(5'd1, 20'h00000);
    run_prog();
    chk("single_nseg", 32'(seg_len.size()), 32'd1);
    chk("single_hold", 32'(seg_len[0]), 32'd4);
    chk("single_word", 32'(seg_word[0]), 32'h41102);
    chk("single_end_instr", 32'(instr), 32'h0);
    chk("single_end_pc", 32'(pc), 32'd1);
    chk("single_end_busy", 32'(busy), 32'd0);

    // Mixed dwell
    load_word(5'd0, 20'h40001);
    load_word(5'd1, 20'h80002);
    load_word(5'd2, 20'hC0003);
    load_word(5'd3, 20'h00000);
    run_prog();
    chk("mixed_nseg", 32'(seg_len.size()), 32'd3);
    chk("mixed_hold0", 32'(seg_len[0]), 32'd4);
    chk("mixed_hold1", 32'(seg_len[1]), 32'd4);
    chk("mixed_hold2", 32'(seg_len[2]), 32'd3);
    chk("mixed_pc2", 32'(seg_pc[2]), 32'd2);
    chk("mixed_end_pc", 32'(pc), 32'd3);
    chk("mixed_end_halted", 32'(halted), 32'd1);

    // End of store
    for (int i = 0; i < 32; i++) load_word(PB'(i), 20'h40000 | 20'(i));
    run_prog();
    chk("eos_nseg", 32'(seg_len.size()), 32'd32);
    chk("eos_first_hold", 32'(seg_len[0]), 32'd4);
    chk("eos_last_hold", 32'(seg_len[31]), 32'd3);
    chk("eos_last_pc", 32'(seg_pc[31]), 32'd31);
    chk("eos_end_pc", 32'(pc), 32'd31);
    chk("eos_end_instr", 32'(instr), 32'h0);
    repeat (3) @(negedge clk);
    chk("eos_no_wrap_pc", 32'(pc), 32'd31);

    // Load while busy is ignored
    load_word(5'd6, 20'h00000);
    fork
      run_prog();
      begin
        repeat (6) @(negedge clk);
        load_en = 1'b1; load_addr = 5'd5; load_data = 20'hFFFFF;
        @(negedge clk);
        load_en = 1'b0;
      end
    join
    run_prog();
    chk("lwb_nseg", 32'(seg_len.size()), 32'd6);
    chk("lwb_pc5", 32'(seg_pc[5]), 32'd5);
    chk("lwb_word5", 32'(seg_word[5]), 32'h40005);

    // Reset during second cycle of a loadR hold
    load_word(5'd0, 20'h80010);
    load_word(5'd1, 20'h00000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 10 && !busy; c++) @(negedge clk);
    chk("rmr_busy_seen", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rmr_instr", 32'(instr), 32'h0);
    chk("rmr_pc", 32'(pc), 32'h0);
    chk("rmr_busy", 32'(busy), 32'h0);
    run_prog();
    chk("rmr_rerun_hold", 32'(seg_len[0]), 32'd5);
    chk("rmr_rerun_word", 32'(seg_word[0]), 32'h80010);
    chk("rmr_end_pc", 32'(pc), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
